// File: rtl/spi_mode0_slave_rx_if.sv
// SPI receive-slave bundle: the three SPI wire inputs from the master plus the
// received-word valid/ready stream and the status flags.
`timescale 1ns/1ps
interface spi_mode0_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  // Receiver side: samples the SPI lines and produces the word stream.
  modport slave (
    input  sclk, mosi, cs_n, rx_ready,
    output rx_data, rx_valid, busy, frame_err, overrun
  );

  // Driver/consumer side: drives the SPI lines and accepts words.
  modport master (
    output sclk, mosi, cs_n, rx_ready,
    input  rx_data, rx_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/spi_mode0_slave_rx.sv
// SPI mode-0 (CPOL=0, CPHA=0) receive-only slave. The SPI lines are
// oversampled in the clk domain through equal-depth synchronizers, SCLK rising
// edges shift MOSI into a word register, and completed words are presented on
// a single-entry valid/ready holding register.
`timescale 1ns/1ps
module spi_mode0_slave_rx #(
  parameter int DATA_W      = 8,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_mode0_slave_rx_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Synchronizer chains; the last stage is the usable synchronized value.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;
  logic rise_s;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
  assign rise_s = sclk_s & ~sclk_prev_q;

  // Shift register contents after absorbing the current synchronized MOSI bit.
  always_comb begin
    shifted_s = shift_q;
    if (LSB_FIRST) begin
      shifted_s = {mosi_s, shift_q[DATA_W-1:1]};
    end else begin
      shifted_s = {shift_q[DATA_W-2:0], mosi_s};
    end
  end

  // Bring the asynchronous SPI lines into the clk domain with equal delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      cs_n_sync_q <= {SYNC_STAGES{1'b1}};
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      sclk_prev_q <= sclk_s;
    end
  end

  // FSM state register; busy mirrors the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_ACTIVE);
    end
  end

  // FSM next state: chip select alone decides between IDLE and ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs_n_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: bit sampling, word completion, holding-register handshake.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // A consumed word frees the holding register; a completion below may refill it.
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_n_s) begin
          shift_d   = {DATA_W{1'b0}};
          bit_cnt_d = CNT_ZERO;
        end else begin
          shift_d   = shift_q;
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_ACTIVE: begin
        if (cs_n_s) begin
          // CS deassert wins over a simultaneous rise; partial words are discarded.
          shift_d     = {DATA_W{1'b0}};
          bit_cnt_d   = CNT_ZERO;
          frame_err_d = (bit_cnt_q != CNT_ZERO);
        end else if (rise_s) begin
          shift_d = shifted_s;
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = CNT_ZERO;
            if (!rx_valid_q || bus.rx_ready) begin
              rx_data_d  = shifted_s;
              rx_valid_d = 1'b1;
            end else begin
              // Holding register still owned by the consumer: drop the new word.
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else begin
          shift_d   = shift_q;
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        shift_d   = {DATA_W{1'b0}};
        bit_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= {DATA_W{1'b0}};
      bit_cnt_q   <= CNT_ZERO;
      rx_data_q   <= {DATA_W{1'b0}};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_mode0_slave_rx.sv
// Directed bench for spi_mode0_slave_rx: one LSB-first instance (A) and one
// MSB-first instance (B) sharing sclk/mosi/rst_n with separate chip selects.
`timescale 1ns/1ps
module tb_spi_mode0_slave_rx;

  logic clk;
  logic rst_n;
  logic sclk;
  logic mosi;
  logic cs_a_n;
  logic cs_b_n;
  logic rdy_a;
  logic rdy_b;

  int n_cmp;
  int n_err;

  spi_mode0_slave_rx_if #(.DATA_W(8)) ifa ();
  spi_mode0_slave_rx_if #(.DATA_W(8)) ifb ();

  assign ifa.sclk     = sclk;
  assign ifa.mosi     = mosi;
  assign ifa.cs_n     = cs_a_n;
  assign ifa.rx_ready = rdy_a;
  assign ifb.sclk     = sclk;
  assign ifb.mosi     = mosi;
  assign ifb.cs_n     = cs_b_n;
  assign ifb.rx_ready = rdy_b;

  spi_mode0_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  spi_mode0_slave_rx #(.DATA_W(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // 50 MHz system clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor state, sampled on the falling clk edge
  logic [7:0] acc_a[$];
  logic [7:0] acc_b[$];
  int vcyc_a, vcyc_b, fe_a, fe_b, ov_a, ov_b, busy_drop_a;
  bit track_busy;

  initial begin
    vcyc_a = 0; vcyc_b = 0; fe_a = 0; fe_b = 0; ov_a = 0; ov_b = 0;
    busy_drop_a = 0; track_busy = 1'b0;
  end

  always @(negedge clk) begin
    if (ifa.rx_valid === 1'b1) vcyc_a++;
    if (ifb.rx_valid === 1'b1) vcyc_b++;
    if (ifa.rx_valid === 1'b1 && rdy_a === 1'b1) acc_a.push_back(ifa.rx_data);
    if (ifb.rx_valid === 1'b1 && rdy_b === 1'b1) acc_b.push_back(ifb.rx_data);
    if (ifa.frame_err === 1'b1) fe_a++;
    if (ifb.frame_err === 1'b1) fe_b++;
    if (ifa.overrun === 1'b1) ov_a++;
    if (ifb.overrun === 1'b1) ov_b++;
    if (track_busy && ifa.busy !== 1'b1) busy_drop_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive nbits of val at 1 MHz SCLK, mode 0 (data set while SCLK low)
  task automatic spi_bits(input logic [7:0] val, input int nbits, input bit lsb);
    for (int i = 0; i < nbits; i++) begin
      mosi = lsb ? val[i] : val[7-i];
      #250;
      sclk = 1'b1;
      #500;
      sclk = 1'b0;
      #250;
    end
  endtask

  initial begin
    int a0, v0, f0, o0, b0, vb0, fb0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    cs_a_n = 1'b1;
    cs_b_n = 1'b1;
    rdy_a = 1'b1;
    rdy_b = 1'b1;

    // 1. reset held while the SPI lines toggle
    for (int i = 0; i < 10; i++) begin
      #100 sclk = ~sclk;
      cs_a_n = ~cs_a_n;
      mosi = ~mosi;
    end
    sclk = 1'b0; cs_a_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    check("rst_rx_valid", {31'd0, ifa.rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, ifa.rx_data}, 32'd0);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);
    check("rst_flags", {30'd0, ifa.frame_err, ifa.overrun}, 32'd0);
    #100 rst_n = 1'b1;
    #200;
    @(negedge clk);
    check("post_rst_busy", {31'd0, ifa.busy}, 32'd0);

    // 2. single LSB-first frame 0x4C
    a0 = acc_a.size(); v0 = vcyc_a; f0 = fe_a; o0 = ov_a;
    cs_a_n = 1'b0; #500;
    spi_bits(8'h4C, 8, 1'b1);
    #500 cs_a_n = 1'b1; #1000;
    check("t2_words", acc_a.size() - a0, 32'd1);
    check("t2_valid_cycles", vcyc_a - v0, 32'd1);
    check("t2_data", {24'd0, acc_a[a0]}, 32'h4C);
    check("t2_frame_err", fe_a - f0, 32'd0);
    check("t2_overrun", ov_a - o0, 32'd0);

    // 3. three back-to-back words under one CS
    a0 = acc_a.size(); o0 = ov_a; f0 = fe_a;
    cs_a_n = 1'b0; #500;
    track_busy = 1'b1;
    spi_bits(8'hA5, 8, 1'b1);
    @(negedge clk);
    check("t3_busy_w0", {31'd0, ifa.busy}, 32'd1);
    spi_bits(8'h3C, 8, 1'b1);
    spi_bits(8'hFF, 8, 1'b1);
    #200;
    track_busy = 1'b0;
    #300 cs_a_n = 1'b1; #1000;
    check("t3_words", acc_a.size() - a0, 32'd3);
    check("t3_word0", {24'd0, acc_a[a0]}, 32'hA5);
    check("t3_word1", {24'd0, acc_a[a0+1]}, 32'h3C);
    check("t3_word2", {24'd0, acc_a[a0+2]}, 32'hFF);
    check("t3_busy_drops", busy_drop_a, 32'd0);
    check("t3_flags", (fe_a - f0) + (ov_a - o0), 32'd0);
    @(negedge clk);
    check("t3_busy_after", {31'd0, ifa.busy}, 32'd0);

    // 4. overrun: consumer stalled across two words
    @(posedge clk); #2 rdy_a = 1'b0;
    a0 = acc_a.size(); o0 = ov_a;
    cs_a_n = 1'b0; #500;
    spi_bits(8'h11, 8, 1'b1);
    spi_bits(8'h22, 8, 1'b1);
    #500 cs_a_n = 1'b1; #1000;
    @(negedge clk);
    check("t4_overrun", ov_a - o0, 32'd1);
    check("t4_valid_held", {31'd0, ifa.rx_valid}, 32'd1);
    check("t4_data_held", {24'd0, ifa.rx_data}, 32'h11);
    @(posedge clk); #2 rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_accepted", acc_a.size() - a0, 32'd1);
    check("t4_accepted_data", {24'd0, acc_a[a0]}, 32'h11);
    check("t4_valid_cleared", {31'd0, ifa.rx_valid}, 32'd0);

    // 5. CS dropped after 5 bits, then a good frame 0x81
    a0 = acc_a.size(); v0 = vcyc_a; f0 = fe_a;
    cs_a_n = 1'b0; #500;
    spi_bits(8'h6B, 5, 1'b1);
    #500 cs_a_n = 1'b1; #1000;
    check("t5_frame_err_cycles", fe_a - f0, 32'd1);
    check("t5_no_valid", vcyc_a - v0, 32'd0);
    cs_a_n = 1'b0; #500;
    spi_bits(8'h81, 8, 1'b1);
    #500 cs_a_n = 1'b1; #1000;
    check("t5_words", acc_a.size() - a0, 32'd1);
    check("t5_data", {24'd0, acc_a[a0]}, 32'h81);
    check("t5_frame_err_total", fe_a - f0, 32'd1);

    // 6. MSB-first instance: 0x83, reset mid-frame, then 0x3C
    b0 = acc_b.size(); vb0 = vcyc_b; fb0 = fe_b;
    cs_b_n = 1'b0; #500;
    spi_bits(8'h83, 8, 1'b0);
    #500 cs_b_n = 1'b1; #1000;
    check("t6_words", acc_b.size() - b0, 32'd1);
    check("t6_data_msb_first", {24'd0, acc_b[b0]}, 32'h83);
    check("t6_a_untouched", acc_a.size() - a0, 32'd1);
    b0 = acc_b.size(); vb0 = vcyc_b; fb0 = fe_b;
    cs_b_n = 1'b0; #500;
    spi_bits(8'h5A, 4, 1'b0);
    rst_n = 1'b0; #100;
    @(negedge clk);
    check("t6_rst_busy", {31'd0, ifb.busy}, 32'd0);
    rst_n = 1'b1; #500;
    @(negedge clk);
    check("t6_reenter_busy", {31'd0, ifb.busy}, 32'd1);
    cs_b_n = 1'b1; #1000;
    check("t6_rst_no_valid", vcyc_b - vb0, 32'd0);
    check("t6_rst_no_frame_err", fe_b - fb0, 32'd0);
    cs_b_n = 1'b0; #500;
    spi_bits(8'h3C, 8, 1'b0);
    #500 cs_b_n = 1'b1; #1000;
    check("t6_after_rst_words", acc_b.size() - b0, 32'd1);
    check("t6_after_rst_data", {24'd0, acc_b[b0]}, 32'h3C);
    check("t6_after_rst_frame_err", fe_b - fb0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
